keyboard_matrix_inject: RTL and testbench

- Parametrised successor to the fixed 8x5 Spectrum key matrix.
- Holds a live ROWS x COLS active-low key matrix driven by pre-translated key events.
- Adds a buffered key-injection path (autotype) with a FIFO of key chords and programmable hold/gap timing.
- Sits between the scancode translator and the ULA port-read logic; key_data is read combinationally by the ULA.

---
 rtl/keyboard_matrix_inject_if.sv | 32 +++
 rtl/keyboard_matrix_inject.sv | 159 +++++++++++++++
 tb/tb_keyboard_matrix_inject.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/keyboard_matrix_inject_if.sv
// Key-event and chord-injection bus for keyboard_matrix_inject.
// master = scancode translator / autotype source, slave = matrix block.
interface keyboard_matrix_inject_if #(
  parameter int ROWS = 8,
  parameter int COLS = 5
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = 2*(RW+CW)+1;

  logic          ev_strobe;
  logic          ev_press;
  logic [RW-1:0] ev_row;
  logic [CW-1:0] ev_col;
  logic          all_up;
  logic          inj_valid;
  logic          inj_ready;
  logic [DW-1:0] inj_data;
  logic          inj_flush;

  modport master (
    output ev_strobe, ev_press, ev_row, ev_col, all_up,
    output inj_valid, inj_data, inj_flush,
    input  inj_ready
  );

  modport slave (
    input  ev_strobe, ev_press, ev_row, ev_col, all_up,
    input  inj_valid, inj_data, inj_flush,
    output inj_ready
  );
endinterface

// File: rtl/keyboard_matrix_inject.sv
// Parametrised active-low key matrix with a live event path and a FIFO-fed
// autotype sequencer. key_data is read combinationally by the ULA.
module keyboard_matrix_inject #(
  parameter int ROWS   = 8,
  parameter int COLS   = 5,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 24,
  parameter int RW     = $clog2(ROWS),
  parameter int CW     = $clog2(COLS)
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  keyboard_matrix_inject_if.slave bus,
  input  logic [HOLD_W-1:0]       hold_cycles,
  input  logic [HOLD_W-1:0]       gap_cycles,
  input  logic [ROWS-1:0]         addr_hi,
  output logic [COLS-1:0]         key_data,
  output logic                    inj_busy,
  output logic [$clog2(DEPTH):0]  inj_count
);
  localparam int DW = 2*(RW+CW)+1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW+1;
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_REL} state_t;

  // Row/column bounds; only bite when ROWS/COLS are not powers of two.
  function automatic logic row_ok(input logic [RW-1:0] r);
    return {1'b0, r} < (RW+1)'(ROWS);
  endfunction
  function automatic logic col_ok(input logic [CW-1:0] c);
    return {1'b0, c} < (CW+1)'(COLS);
  endfunction

  logic [ROWS-1:0][COLS-1:0] live_q, inj_q, chord_mask;
  logic [DW-1:0]             fifo_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]             cnt_q;
  logic [HOLD_W-1:0]         tmr_q;
  state_t                    state_q, state_d;
  logic                      pop, push, load_gap, tmr_last;

  logic [DW-1:0] head;
  logic [CW-1:0] h_col1, h_col2;
  logic [RW-1:0] h_row1, h_row2;
  logic          h_use2;

  assign head   = fifo_q[rd_ptr_q];
  assign h_col1 = head[CW-1:0];
  assign h_row1 = head[CW +: RW];
  assign h_col2 = head[RW+CW +: CW];
  assign h_row2 = head[RW+2*CW +: RW];
  assign h_use2 = head[DW-1];

  // Last timer cycle: a loaded value of 0 behaves like 1.
  assign tmr_last = (tmr_q[HOLD_W-1:1] == '0);

  assign bus.inj_ready = (cnt_q < FULL);
  // A pop frees a slot at the same edge, so a full FIFO still takes the
  // offered chord then; inj_ready stays tied to the registered count.
  assign push      = bus.inj_valid && (bus.inj_ready || pop) && !bus.inj_flush;
  assign inj_busy  = (state_q != S_IDLE) || (cnt_q != '0);
  assign inj_count = cnt_q;

  // Live matrix: all_up beats a same-cycle event; out-of-range events drop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      live_q <= '1;
    else if (bus.all_up)
      live_q <= '1;
    else if (bus.ev_strobe && row_ok(bus.ev_row) && col_ok(bus.ev_col))
      live_q[bus.ev_row][bus.ev_col] <= ~bus.ev_press;
  end

  // Chord storage; contents need no reset, pointers/count guard validity.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q] <= bus.inj_data;
  end

  // FIFO pointers and occupancy; flush discards everything incl. a same-cycle push.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (bus.inj_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + NW'(push) - NW'(pop);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)          state_q <= S_IDLE;
    else if (bus.inj_flush) state_q <= S_IDLE;
    else                   state_q <= state_d;
  end

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cnt_q != '0) state_d = S_PRESS;
      S_PRESS: if (tmr_last)    state_d = S_REL;
      S_REL:   if (tmr_last)    state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs: pop the head from IDLE, switch to gap timing at end of PRESS.
  always_comb begin
    pop      = 1'b0;
    load_gap = 1'b0;
    case (state_q)
      S_IDLE:  pop      = (cnt_q != '0);
      S_PRESS: load_gap = tmr_last;
      default: ;
    endcase
  end

  // Decode the head chord into an active-low mask; bad coordinates drop per key.
  always_comb begin
    chord_mask = '1;
    if (row_ok(h_row1) && col_ok(h_col1))
      chord_mask[h_row1][h_col1] = 1'b0;
    if (h_use2 && row_ok(h_row2) && col_ok(h_col2))
      chord_mask[h_row2][h_col2] = 1'b0;
  end

  // Hold/gap timer; durations are sampled only when loaded.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)            tmr_q <= '0;
    else if (bus.inj_flush)  tmr_q <= '0;
    else if (pop)            tmr_q <= hold_cycles;
    else if (load_gap)       tmr_q <= gap_cycles;
    else if (tmr_q != '0)    tmr_q <= tmr_q - HOLD_W'(1);
  end

  // Injected matrix: chord pressed from pop until the end of PRESS.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)           inj_q <= '1;
    else if (bus.inj_flush) inj_q <= '1;
    else if (pop)           inj_q <= chord_mask;
    else if (load_gap)      inj_q <= '1;
  end

  // Port read: AND of every selected row, live and injected combined.
  always_comb begin
    key_data = '1;
    for (int r = 0; r < ROWS; r++)
      if (!addr_hi[r]) key_data = key_data & live_q[r] & inj_q[r];
  end
endmodule

// File: tb/tb_keyboard_matrix_inject.sv
// Directed bench for keyboard_matrix_inject: live path, chord timing via an
// expected-press queue, FIFO fill/backpressure, flush and async reset.
module tb_keyboard_matrix_inject;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [23:0] hold_cycles, gap_cycles;
  logic [7:0]  addr_hi;
  logic [4:0]  key_data;
  logic        inj_busy;
  logic [4:0]  inj_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { logic [4:0] kd; int len; } exp_t;
  exp_t       exp_q[$];
  logic       mon_en;
  logic [4:0] prev_kd;
  int         press_start, last_press, cur_len, exp_spacing;

  keyboard_matrix_inject_if #(.ROWS(8), .COLS(5)) bus();

  keyboard_matrix_inject dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .hold_cycles (hold_cycles),
    .gap_cycles  (gap_cycles),
    .addr_hi     (addr_hi),
    .key_data    (key_data),
    .inj_busy    (inj_busy),
    .inj_count   (inj_count)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [12:0] chord(input logic u, input int r2, input int c2,
                                        input int r1, input int c1);
    return {u, r2[2:0], c2[2:0], r1[2:0], c1[2:0]};
  endfunction

  // Compare each observed injected press against the next expected chord.
  task automatic monitor_sample();
    exp_t e;
    logic [4:0] kd;
    kd = key_data;
    if (prev_kd == 5'h1F && kd != 5'h1F) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_press", kd, 5'h1F);
      end else begin
        e = exp_q.pop_front();
        cur_len = e.len;
        chk("sb_chord_keys", kd, e.kd);
        if (last_press >= 0) chk("sb_spacing", cyc - last_press, exp_spacing);
        last_press  = cyc;
        press_start = cyc;
      end
    end else if (prev_kd != 5'h1F && kd == 5'h1F) begin
      chk("sb_hold_len", cyc - press_start, cur_len);
    end
    prev_kd = kd;
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    if (mon_en) monitor_sample();
  endtask

  task automatic live_ev(input logic press, input int row, input int col, input logic up);
    bus.ev_strobe = 1'b1;
    bus.ev_press  = press;
    bus.ev_row    = row[2:0];
    bus.ev_col    = col[2:0];
    bus.all_up    = up;
    step();
    bus.ev_strobe = 1'b0;
    bus.all_up    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.ev_strobe = 1'b0; bus.ev_press = 1'b0; bus.ev_row = '0; bus.ev_col = '0;
    bus.all_up = 1'b0; bus.inj_valid = 1'b0; bus.inj_data = '0; bus.inj_flush = 1'b0;
    hold_cycles = 24'd0; gap_cycles = 24'd0; addr_hi = 8'hFE;
    mon_en = 1'b0; prev_kd = 5'h1F; press_start = 0; last_press = -1;
    cur_len = 0; exp_spacing = 0;

    // Reset state
    step(); step();
    chk("rst_key_data", key_data, 5'h1F);
    chk("rst_ready", bus.inj_ready, 1'b1);
    chk("rst_count", inj_count, 5'd0);
    chk("rst_busy", inj_busy, 1'b0);
    reset_n = 1'b1;
    step();
    chk("post_rst_key_data", key_data, 5'h1F);

    // Live matrix
    live_ev(1'b1, 0, 0, 1'b0);
    chk("live_press_r0", key_data, 5'h1E);
    addr_hi = 8'hFD; #1;
    chk("live_other_row", key_data, 5'h1F);
    addr_hi = 8'hFE;
    live_ev(1'b0, 0, 0, 1'b0);
    chk("live_release", key_data, 5'h1F);
    live_ev(1'b1, 0, 7, 1'b0);
    addr_hi = 8'hFC; #1;
    chk("live_col_oob", key_data, 5'h1F);
    live_ev(1'b1, 1, 2, 1'b0);
    addr_hi = 8'hFD; #1;
    chk("live_r1c2", key_data, 5'h1B);
    live_ev(1'b1, 0, 0, 1'b0);
    addr_hi = 8'hFC; #1;
    chk("live_multi_row", key_data, 5'h1A);
    addr_hi = 8'hFF; #1;
    chk("live_no_row", key_data, 5'h1F);
    live_ev(1'b1, 2, 1, 1'b1);
    addr_hi = 8'h00; #1;
    chk("all_up_wins", key_data, 5'h1F);

    // Chord timing through the expected-press queue
    hold_cycles = 24'd4; gap_cycles = 24'd2; addr_hi = 8'hF6;
    exp_spacing = 7; last_press = -1; prev_kd = 5'h1F; mon_en = 1'b1;
    bus.inj_valid = 1'b1;
    exp_q.push_back('{5'h0E, 4}); bus.inj_data = chord(1'b1, 0, 0, 3, 4); step();
    exp_q.push_back('{5'h1D, 4}); bus.inj_data = chord(1'b0, 3, 0, 0, 1); step();
    exp_q.push_back('{5'h1B, 4}); bus.inj_data = chord(1'b1, 0, 7, 3, 2); step();
    bus.inj_valid = 1'b0;
    for (int i = 0; i < 100 && inj_busy; i++) step();
    step();
    mon_en = 1'b0;
    chk("chords_drained", inj_busy, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    // FIFO fill and backpressure (long hold keeps the sequencer busy)
    hold_cycles = 24'd40; gap_cycles = 24'd1; addr_hi = 8'h00;
    bus.inj_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.inj_data = chord(1'b0, 0, 0, 4 + (i % 4), i % 5);
      step();
    end
    chk("fill_count", inj_count, 5'd16);
    chk("fill_ready", bus.inj_ready, 1'b0);
    bus.inj_data = chord(1'b0, 0, 0, 7, 4);
    step();
    chk("reject_count", inj_count, 5'd16);
    for (int i = 0; i < 100 && key_data != 5'h1F; i++) step();
    chk("first_chord_released", key_data, 5'h1F);
    for (int i = 0; i < 100 && key_data == 5'h1F; i++) step();
    chk("second_chord_pressed", key_data != 5'h1F, 1'b1);
    chk("full_pop_push_count", inj_count, 5'd16);
    chk("full_pop_push_ready", bus.inj_ready, 1'b0);
    bus.inj_valid = 1'b0;

    // Flush mid-PRESS; live key survives
    live_ev(1'b1, 1, 0, 1'b0);
    chk("pre_flush_kd", key_data, 5'h1C);
    bus.inj_flush = 1'b1; bus.inj_valid = 1'b1; bus.inj_data = chord(1'b0, 0, 0, 6, 3);
    step();
    bus.inj_flush = 1'b0; bus.inj_valid = 1'b0;
    chk("flush_kd_live_only", key_data, 5'h1E);
    chk("flush_count", inj_count, 5'd0);
    chk("flush_busy", inj_busy, 1'b0);
    chk("flush_ready", bus.inj_ready, 1'b1);
    step(); step();
    chk("flush_push_dropped", inj_count, 5'd0);
    chk("flush_stays_idle", key_data, 5'h1E);
    bus.all_up = 1'b1; step(); bus.all_up = 1'b0;
    chk("all_up_clear", key_data, 5'h1F);

    // Same key held by live and injected paths
    hold_cycles = 24'd6;
    live_ev(1'b1, 3, 4, 1'b0);
    bus.inj_valid = 1'b1; bus.inj_data = chord(1'b0, 0, 0, 3, 4); step();
    bus.inj_valid = 1'b0; step();
    live_ev(1'b0, 3, 4, 1'b0);
    chk("overlap_held", key_data, 5'h0F);
    for (int i = 0; i < 20 && key_data != 5'h1F; i++) step();
    chk("overlap_released", key_data, 5'h1F);
    for (int i = 0; i < 20 && inj_busy; i++) step();
    chk("overlap_idle", inj_busy, 1'b0);

    // Async reset mid-PRESS with live keys down
    hold_cycles = 24'd40;
    bus.inj_valid = 1'b1;
    bus.inj_data = chord(1'b0, 0, 0, 2, 3); step();
    bus.inj_data = chord(1'b0, 0, 0, 6, 2); step();
    bus.inj_valid = 1'b0;
    live_ev(1'b1, 5, 0, 1'b0);
    chk("pre_reset_kd", key_data, 5'h16);
    chk("pre_reset_count", inj_count, 5'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_kd", key_data, 5'h1F);
    chk("async_reset_count", inj_count, 5'd0);
    chk("async_reset_busy", inj_busy, 1'b0);
    @(posedge clk_sys); #1 reset_n = 1'b1;
    step();
    chk("post_reset_count", inj_count, 5'd0);
    chk("post_reset_idle", inj_busy, 1'b0);
    step(); step();
    chk("post_reset_kd", key_data, 5'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
